// File: rtl/mxv_load_sequencer.sv
// Load sequencer for one matrix-vector multiply: routes an N*N + N word stream
// into the row and vector FIFOs, kicks the datapath and waits for it to finish.
module mxv_load_sequencer #(
    parameter int WORD_LENGTH = 8,
    parameter int MAX_N       = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WORD_LENGTH-1:0] matrix_length,
    input  logic [WORD_LENGTH-1:0] data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [MAX_N-1:0]       row_full,
    input  logic                   vec_full,
    output logic [MAX_N-1:0]       push_row,
    output logic                   push_vec,
    output logic [WORD_LENGTH-1:0] push_data,
    output logic                   mxv_start,
    input  logic                   compute_done,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [WORD_LENGTH-1:0] n_latched
);

    localparam int CW = $clog2(MAX_N) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_LOAD_MAT     = 3'd1,
        S_LOAD_VEC     = 3'd2,
        S_KICK         = 3'd3,
        S_COMPUTE_WAIT = 3'd4,
        S_DONE         = 3'd5,
        S_ERR          = 3'd6
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          row_r;
    logic [CW-1:0]          col_r;
    logic [TW-1:0]          tcnt_r;
    logic                   error_r;
    logic [WORD_LENGTH-1:0] n_r;

    logic [MAX_N-1:0] row_onehot_s;
    logic             row_blocked_s;
    logic             last_col_s;
    logic             last_row_s;
    logic             n_legal_s;
    logic             timeout_s;
    logic             tcnt_max_s;
    logic             accept_s;

    // Index decode and terminal-count compares; all bounds derive from n_r.
    always_comb begin
        row_onehot_s  = {{(MAX_N-1){1'b0}}, 1'b1} << row_r;
        row_blocked_s = |(row_full & row_onehot_s);
        last_col_s    = (WORD_LENGTH'(col_r) == (n_r - WORD_LENGTH'(1)));
        last_row_s    = (WORD_LENGTH'(row_r) == (n_r - WORD_LENGTH'(1)));
        n_legal_s     = (matrix_length != {WORD_LENGTH{1'b0}}) &&
                        (matrix_length <= WORD_LENGTH'(MAX_N));
        // ERR is entered on the edge where the counter would reach TIMEOUT-1.
        timeout_s     = (tcnt_r >= TW'(TIMEOUT - 2));
        tcnt_max_s    = (tcnt_r == TW'(TIMEOUT - 1));
    end

    // Handshake and push strobes; abort masks every side effect in its cycle.
    always_comb begin
        data_ready = 1'b0;
        accept_s   = 1'b0;
        push_row   = {MAX_N{1'b0}};
        push_vec   = 1'b0;
        mxv_start  = 1'b0;
        if (abort) begin
            data_ready = 1'b0;
        end else begin
            case (state_r)
                S_LOAD_MAT: begin
                    data_ready = !row_blocked_s;
                    accept_s   = data_valid && !row_blocked_s;
                    push_row   = accept_s ? row_onehot_s : {MAX_N{1'b0}};
                end
                S_LOAD_VEC: begin
                    data_ready = !vec_full;
                    accept_s   = data_valid && !vec_full;
                    push_vec   = accept_s;
                end
                S_KICK: begin
                    mxv_start = 1'b1;
                end
                default: begin
                    data_ready = 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        push_data = data_in;
        busy      = (state_r != S_IDLE);
        done      = (state_r == S_DONE);
        error     = error_r;
        n_latched = n_r;
    end

    // Sequencer FSM with its row/column/timeout counters and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            row_r   <= {CW{1'b0}};
            col_r   <= {CW{1'b0}};
            tcnt_r  <= {TW{1'b0}};
            error_r <= 1'b0;
            n_r     <= {WORD_LENGTH{1'b0}};
        end else if (abort) begin
            state_r <= S_IDLE;
            row_r   <= {CW{1'b0}};
            col_r   <= {CW{1'b0}};
            tcnt_r  <= {TW{1'b0}};
            error_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        n_r    <= matrix_length;
                        row_r  <= {CW{1'b0}};
                        col_r  <= {CW{1'b0}};
                        tcnt_r <= {TW{1'b0}};
                        if (n_legal_s) begin
                            state_r <= S_LOAD_MAT;
                            error_r <= 1'b0;
                        end else begin
                            state_r <= S_ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
                S_LOAD_MAT: begin
                    if (accept_s) begin
                        if (last_col_s) begin
                            col_r <= {CW{1'b0}};
                            row_r <= row_r + CW'(1);
                            if (last_row_s) begin
                                state_r <= S_LOAD_VEC;
                            end
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end
                end
                S_LOAD_VEC: begin
                    if (accept_s) begin
                        if (last_col_s) begin
                            col_r   <= {CW{1'b0}};
                            state_r <= S_KICK;
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end
                end
                S_KICK: begin
                    tcnt_r  <= {TW{1'b0}};
                    state_r <= S_COMPUTE_WAIT;
                end
                S_COMPUTE_WAIT: begin
                    if (compute_done) begin
                        state_r <= S_DONE;
                    end else begin
                        if (!tcnt_max_s) begin
                            tcnt_r <= tcnt_r + TW'(1);
                        end
                        if (timeout_s) begin
                            state_r <= S_ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                S_ERR: begin
                    if (start) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxv_load_sequencer.sv
// Directed bench for mxv_load_sequencer with hand-computed expectations.
module tb_mxv_load_sequencer;

    localparam int WL = 8;
    localparam int MN = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [WL-1:0] matrix_length;
    logic [WL-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [MN-1:0] row_full;
    logic          vec_full;
    logic [MN-1:0] push_row;
    logic          push_vec;
    logic [WL-1:0] push_data;
    logic          mxv_start;
    logic          compute_done;
    logic          busy;
    logic          done;
    logic          error;
    logic [WL-1:0] n_latched;

    int checks = 0;
    int errors = 0;
    int row_cnt [MN] = '{default: 0};
    int vec_cnt = 0;
    int snap_row [MN];
    int snap_vec;

    logic [7:0] t1_row [6] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h00, 8'h00};
    logic       t1_vec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    mxv_load_sequencer #(.WORD_LENGTH(WL), .MAX_N(MN), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .matrix_length(matrix_length), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .row_full(row_full), .vec_full(vec_full),
        .push_row(push_row), .push_vec(push_vec), .push_data(push_data),
        .mxv_start(mxv_start), .compute_done(compute_done), .busy(busy),
        .done(done), .error(error), .n_latched(n_latched)
    );

    always #5 clk = ~clk;

    // Push scoreboard: counts FIFO pushes per destination at each clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < MN; i++) begin
            if (push_row[i]) row_cnt[i] <= row_cnt[i] + 1;
        end
        if (push_vec) vec_cnt <= vec_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        for (int i = 0; i < MN; i++) snap_row[i] = row_cnt[i];
        snap_vec = vec_cnt;
    endtask

    function automatic int total_delta();
        int s = vec_cnt - snap_vec;
        for (int i = 0; i < MN; i++) s += row_cnt[i] - snap_row[i];
        return s;
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; matrix_length = 8'd0;
        data_in = 8'hA5; data_valid = 1'b0; row_full = 8'h00; vec_full = 1'b0;
        compute_done = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_n_latched", n_latched, 8'd0);
        check("rst_push_row", push_row, 8'h00);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_push_data", push_data, 8'hA5);
        reset = 1'b1;
        tick;

        // N=2 full operation
        start = 1'b1; matrix_length = 8'd2;
        #1 check("idle_ready", data_ready, 1'b0);
        tick;
        start = 1'b0;
        check("t1_busy", busy, 1'b1);
        check("t1_n", n_latched, 8'd2);
        data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(i + 1);
            #1;
            check("t1_push_row", push_row, t1_row[i]);
            check("t1_push_vec", push_vec, t1_vec[i]);
            check("t1_push_data", push_data, 8'(i + 1));
            tick;
        end
        data_valid = 1'b0;
        #1 check("t1_kick", mxv_start, 1'b1);
        tick;
        check("t1_kick_once", mxv_start, 1'b0);
        repeat (4) tick;
        compute_done = 1'b1;
        #1 check("t1_not_done_yet", done, 1'b0);
        tick;
        compute_done = 1'b0;
        check("t1_done", done, 1'b1);
        tick;
        check("t1_done_pulse", done, 1'b0);
        check("t1_idle", busy, 1'b0);

        // Illegal N=0 and N=9, then recovery with N=3
        snap;
        start = 1'b1; matrix_length = 8'd0; data_valid = 1'b1;
        tick;
        start = 1'b0;
        check("t2_err_n0", error, 1'b1);
        check("t2_err_busy", busy, 1'b1);
        check("t2_err_ready", data_ready, 1'b0);
        tick;
        check("t2_err_sticky", error, 1'b1);
        start = 1'b1; matrix_length = 8'd9;
        tick;
        check("t2_err_exit", busy, 1'b0);
        tick;
        check("t2_err_n9", error, 1'b1);
        check("t2_n9_latched", n_latched, 8'd9);
        matrix_length = 8'd3;
        tick;
        tick;
        start = 1'b0; data_valid = 1'b0;
        #1;
        check("t2_err_clear", error, 1'b0);
        check("t2_load_busy", busy, 1'b1);
        check("t2_n3", n_latched, 8'd3);
        check("t2_ready", data_ready, 1'b1);
        check("t2_no_push", total_delta(), 0);

        // N=3 with row 1 blocked for 4 cycles
        snap;
        data_valid = 1'b1;
        for (int w = 0; w < 12; w++) begin
            if (w == 3) begin
                row_full = 8'h02;
                repeat (4) begin
                    data_in = 8'hEE;
                    #1;
                    check("t3_blocked_ready", data_ready, 1'b0);
                    check("t3_blocked_push", push_row, 8'h00);
                    tick;
                end
                row_full = 8'h00;
            end
            data_in = 8'(w);
            #1 check("t3_ready", data_ready, 1'b1);
            tick;
        end
        data_valid = 1'b0;
        #1 check("t3_kick", mxv_start, 1'b1);
        abort = 1'b1;
        #1 check("t3_abort_kick", mxv_start, 1'b0);
        tick;
        abort = 1'b0;
        check("t3_abort_idle", busy, 1'b0);
        for (int i = 0; i < 3; i++) check("t3_row_pushes", row_cnt[i] - snap_row[i], 3);
        check("t3_vec_pushes", vec_cnt - snap_vec, 3);

        // N=4 aborted after 5 words, then N=1
        snap;
        start = 1'b1; matrix_length = 8'd4;
        tick;
        start = 1'b0; data_valid = 1'b1;
        for (int w = 0; w < 5; w++) begin
            data_in = 8'(8'h40 + w);
            tick;
        end
        abort = 1'b1;
        #1;
        check("t4_abort_push", push_row, 8'h00);
        check("t4_abort_ready", data_ready, 1'b0);
        tick;
        abort = 1'b0; data_valid = 1'b0;
        check("t4_abort_idle", busy, 1'b0);
        check("t4_row0", row_cnt[0] - snap_row[0], 4);
        check("t4_row1", row_cnt[1] - snap_row[1], 1);
        check("t4_total", total_delta(), 5);
        start = 1'b1; matrix_length = 8'd1;
        tick;
        start = 1'b0; data_valid = 1'b1; data_in = 8'h11;
        #1 check("t4_n1_mat", push_row, 8'h01);
        tick;
        data_in = 8'h22;
        #1;
        check("t4_n1_vec", push_vec, 1'b1);
        check("t4_n1_vec_row", push_row, 8'h00);
        tick;
        data_valid = 1'b0;
        #1 check("t4_n1_kick", mxv_start, 1'b1);

        // Timeout with no compute_done
        repeat (15) tick;
        check("t5_pre_timeout", error, 1'b0);
        check("t5_pre_busy", busy, 1'b1);
        tick;
        check("t5_timeout_err", error, 1'b1);
        check("t5_timeout_busy", busy, 1'b1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("t5_abort_clears", error, 1'b0);
        check("t5_idle", busy, 1'b0);

        // compute_done on the timeout cycle; start ignored during LOAD_VEC
        start = 1'b1; matrix_length = 8'd2;
        tick;
        start = 1'b0; data_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            data_in = 8'(w);
            tick;
        end
        start = 1'b1; matrix_length = 8'd5;
        #1 check("t6_vec0", push_vec, 1'b1);
        tick;
        check("t6_n_kept", n_latched, 8'd2);
        check("t6_vec1", push_vec, 1'b1);
        tick;
        start = 1'b0; data_valid = 1'b0;
        #1 check("t6_kick", mxv_start, 1'b1);
        repeat (15) tick;
        compute_done = 1'b1;
        tick;
        compute_done = 1'b0;
        check("t6_done_wins", done, 1'b1);
        check("t6_no_error", error, 1'b0);
        tick;
        check("t6_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxv_load_sequencer.md
Name: mxv_load_sequencer

Overview:
- Top-level sequencer for one matrix-vector multiply operation.
- Takes a serial word stream. The first N*N words are routed row-major into per-row matrix FIFOs; the next N words go into the vector FIFO.
- Then triggers the pop/compute controllers and waits for the datapath to finish.
- Sits between the input stream source (UART/host) and the FIFO + pop-control + MAC datapath.

Parameters:
- WORD_LENGTH, 8, data and length width.
- MAX_N, 8, maximum matrix dimension and number of row FIFOs.
- TIMEOUT, 1024, cycles to wait in COMPUTE_WAIT before flagging an error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  begin a new operation; sampled only in IDLE
- abort  in  1  return to IDLE from any state
- matrix_length  in  WORD_LENGTH  N, latched on start
- data_in  in  WORD_LENGTH  stream word
- data_valid  in  1  data_in is valid
- data_ready  out  1  sequencer accepts data_in this cycle
- row_full  in  MAX_N  full flags of the row FIFOs
- vec_full  in  1  full flag of the vector FIFO
- push_row  out  MAX_N  one-hot push to row FIFO
- push_vec  out  1  push to the vector FIFO
- push_data  out  WORD_LENGTH  data to the FIFOs
- mxv_start  out  1  start pulse to the pop controllers
- compute_done  in  1  datapath finished
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky error flag
- n_latched  out  WORD_LENGTH  N currently in use

Behaviour:
- Reset (async, reset=0): state IDLE, all counters 0, n_latched=0, error=0. All outputs 0 except push_data, which follows data_in.
- States: IDLE, LOAD_MAT, LOAD_VEC, KICK, COMPUTE_WAIT, DONE, ERR.
- IDLE:
  - On start=1: latch n_latched=matrix_length and clear the row/col/timeout counters.
  - If 1<=matrix_length<=MAX_N, go to LOAD_MAT; otherwise go to ERR.
  - error clears when start is accepted with a legal N.
- LOAD_MAT:
  - Target row = row counter.
  - data_ready = !row_full[row].
  - Accept when data_valid && data_ready. In that same cycle (combinational), push_row[row]=1 and push_data=data_in.
  - On accept, col increments. When col==N-1: col<=0, row increments.
  - The accept that completes row N-1 / col N-1 moves the state to LOAD_VEC.
  - Exactly N*N pushes occur in this state.
- LOAD_VEC:
  - data_ready = !vec_full.
  - Accept pushes push_vec=1 and increments col.
  - The Nth accept moves the state to KICK.
- KICK: mxv_start=1 for exactly one cycle, clear the timeout counter, then go to COMPUTE_WAIT.
- COMPUTE_WAIT:
  - compute_done=1 moves the state to DONE.
  - Otherwise the timeout counter increments.
  - When it reaches TIMEOUT-1 without compute_done, go to ERR.
  - If compute_done and the timeout occur in the same cycle, compute_done wins.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: error=1 (sticky); data_ready=0; no pushes. Exits to IDLE only on abort or on start (start is then treated as in IDLE on the following cycle).
- busy=1 in every state except IDLE.
- Flow control:
  - data_ready=0 in IDLE, KICK, COMPUTE_WAIT, DONE and ERR.
  - data_valid with data_ready=0 is neither consumed nor pushed.
  - A full flag deasserting re-enables acceptance the same cycle.
- abort:
  - Highest priority in every state. Next state is IDLE and counters are cleared.
  - In the abort cycle, push_row/push_vec/mxv_start are forced to 0 and data_ready=0.
  - error is not set by abort; a pending error is cleared.
  - FIFO contents are not flushed; flushing is the parent's responsibility.
- start while busy: ignored; matrix_length changes after latch have no effect.
- Widths:
  - row/col counters are $clog2(MAX_N)+1 bits.
  - Comparisons use n_latched; N*N is never formed explicitly.
  - The timeout counter is $clog2(TIMEOUT)+1 bits and saturates.

Test Plan:
- N=2, start pulse, stream 1,2,3,4,5,6 with data_valid held.
  - Required: push_row=01,01,10,10, then push_vec twice.
  - Then mxv_start one cycle; compute_done 5 cycles later gives done one cycle and busy=0.
- N=0 and N=9 on start -> ERR, error=1, no pushes. A following start with N=3 clears error and enters LOAD_MAT.
- N=3, row_full[1]=1 during row 1 for 4 cycles -> data_ready=0 and no push; row 1 loads on release, and the total pushes per row are exactly 3.
- N=4, abort after 5 matrix words -> IDLE next cycle, no push in the abort cycle. A new start with N=1 loads 1 matrix word and 1 vector word.
- TIMEOUT=16, compute_done never asserted -> ERR exactly 16 cycles after KICK, error=1.
- compute_done asserted on the timeout cycle -> DONE, error=0. start pulses during LOAD_VEC are ignored and n_latched is unchanged.
